request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Memory-request sequencer directly downstream of the instruction decoder.
//  - Consumes the decoder's data-access requests (dcuREN/dcuWEN) and the
//    memory controller's ihit/dhit.
//  - Drives imemREN/dmemREN/dmemWEN and the single-cycle PC-advance strobe.
//  - Holds a data access until it is served, latches HALT, and flags
//    data-memory accesses that never complete.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles in MEM before mem_timeout sets; 0 = check disabled
//  TO_W         8    width of timeout counter; must satisfy MEM_TIMEOUT < 2**TO_W
// PORTS
//  CLK          in   1   clock, rising edge
//  nRST         in   1   asynchronous active-low reset
//  dcuREN       in   1   decoded instr is a load (valid when ihit)
//  dcuWEN       in   1   decoded instr is a store (valid when ihit)
//  cu_halt      in   1   decoded instr is HALT (valid when ihit)
//  ihit         in   1   instruction-memory read served this cycle
//  dhit         in   1   data-memory access served this cycle
//  imemREN      out  1   instruction fetch request
//  dmemREN      out  1   data read request
//  dmemWEN      out  1   data write request
//  pc_en        out  1   advance PC / commit instr this cycle (1-cycle pulse)
//  halt         out  1   processor halted (sticky)
//  mem_timeout  out  1   data access exceeded MEM_TIMEOUT (sticky)
//  instr_cnt    out  32  committed-instruction count (perf option)
//  stall_cnt    out  32  cycles spent in MEM (perf option)
// BEHAVIOUR
//  - Reset (nRST=0, async): state=FETCH, imemREN=1, dmemREN=dmemWEN=0,
//    halt=0, mem_timeout=0, counters=0, timeout counter=0.
//    pc_en is 0 while nRST=0.
//  - FSM states (reqstate_t):
//    - FETCH: imemREN=1, dmemREN=dmemWEN=0. On ihit:
//      - cu_halt=1 -> HALTED, pc_en=0.
//      - else dcuREN|dcuWEN -> MEM; latch dmemREN<=dcuREN,
//        dmemWEN<=dcuWEN&~dcuREN; pc_en=0.
//      - else pc_en=1 (combinational, same cycle as ihit); stay in FETCH.
//      - dhit is ignored in FETCH.
//    - MEM: imemREN=0; dmemREN/dmemWEN held at their latched values.
//      On dhit: pc_en=1; dmemREN/dmemWEN clear next edge; -> FETCH.
//      ihit is ignored in MEM.
//    - HALTED: all requests 0, pc_en=0, halt=1. Terminal until reset.
//  - Request outputs are registered; pc_en is combinational from state and hits.
//  - dcuREN & dcuWEN both 1: load wins; the write is dropped.
//  - Timeout counter:
//    - Cleared on entry to MEM; increments each MEM cycle without dhit;
//      saturates at 2**TO_W-1.
//    - mem_timeout sets when count == MEM_TIMEOUT (MEM_TIMEOUT != 0).
//    - FSM keeps waiting after timeout; only reset clears the flag.
//  - dhit on the same cycle the counter reaches MEM_TIMEOUT: access completes
//    and mem_timeout is NOT set.
//  - nRST asserted mid-MEM aborts the access immediately (requests drop async).
// CONFIGURATION
//  - REQ_PERF_CNT_EN defined:
//    - instr_cnt += 1 on each pc_en pulse.
//    - stall_cnt += 1 on each cycle in MEM.
//    - Both 32-bit, wrap modulo 2**32.
//  - REQ_PERF_CNT_EN undefined: ports remain, tied to 32'h0, no counter flops.
// STRUCTURE
//  - cpu_types_pkg: reqstate_t enum {FETCH, MEM, HALTED}; WORD_W = 32.
//  - Sub-module sat_counter #(W): clear/enable/saturate; one instance for
//    the timeout counter. Perf counters are inline.
// TESTING
//  - ALU stream: ihit every cycle, no dcu requests -> pc_en=1 each ihit cycle,
//    imemREN stays 1, dmem* stay 0.
//  - Load: ihit with dcuREN=1, dhit 3 cycles later -> dmemREN=1 for exactly
//    3 cycles, imemREN=0, one pc_en on the dhit cycle, then FETCH.
//  - Both dcuREN=dcuWEN=1 on ihit -> dmemREN=1, dmemWEN=0.
//  - MEM_TIMEOUT=4, no dhit -> mem_timeout=1 after 4 MEM cycles;
//    late dhit -> pc_en=1, flag stays 1. Repeat with dhit on cycle 4
//    -> flag stays 0.
//  - cu_halt on ihit -> halt=1 next edge; all requests 0; pc_en never pulses;
//    later ihit/dhit ignored.
//  - nRST pulse mid-MEM -> dmem* drop without a clock edge, imemREN=1;
//    with REQ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types for the request sequencer: FSM state encoding and word width
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MEM    = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - decoder/memory-side handshake bundle of request_unit
interface request_unit_if;
    import cpu_types_pkg::*;

    logic              dcuREN;
    logic              dcuWEN;
    logic              cu_halt;
    logic              ihit;
    logic              dhit;
    logic              imemREN;
    logic              dmemREN;
    logic              dmemWEN;
    logic              pc_en;
    logic              halt;
    logic              mem_timeout;
    logic [WORD_W-1:0] instr_cnt;
    logic [WORD_W-1:0] stall_cnt;

    modport master (
        input  dcuREN, dcuWEN, cu_halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pc_en, halt, mem_timeout,
        output instr_cnt, stall_cnt
    );

    modport slave (
        output dcuREN, dcuWEN, cu_halt, ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, pc_en, halt, mem_timeout,
        input  instr_cnt, stall_cnt
    );

endinterface

// File: rtl/request_unit_sat_counter.sv
// rtl/request_unit_sat_counter.sv - W-bit counter with synchronous clear, enable and saturation at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/data memory request sequencer with sticky halt and data-access timeout
// Optional performance counters (instr_cnt/stall_cnt) are built when REQ_PERF_CNT_EN is defined.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    request_unit_if.master bus
);

    localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(MEM_TIMEOUT);
    localparam bit            TO_EN    = (MEM_TIMEOUT != 0);

    reqstate_t      state_q, state_d;
    logic           imemren_q, imemren_d;
    logic           dmemren_q, dmemren_d;
    logic           dmemwen_q, dmemwen_d;
    logic           timeout_q, timeout_d;
    logic           pc_en_c;
    logic           mem_start;
    logic           mem_wait;
    logic           to_reach;
    logic [TO_W-1:0] to_cnt;

    always_comb begin
        state_d   = state_q;
        imemren_d = imemren_q;
        dmemren_d = dmemren_q;
        dmemwen_d = dmemwen_q;
        pc_en_c   = 1'b0;
        mem_start = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.ihit) begin
                    if (bus.cu_halt) begin
                        state_d   = HALTED;
                        imemren_d = 1'b0;
                    end else if (bus.dcuREN || bus.dcuWEN) begin
                        // a load and store together keeps only the load
                        state_d   = MEM;
                        imemren_d = 1'b0;
                        dmemren_d = bus.dcuREN;
                        dmemwen_d = bus.dcuWEN & ~bus.dcuREN;
                        mem_start = 1'b1;
                    end else begin
                        pc_en_c = 1'b1;
                    end
                end
            end
            MEM: begin
                if (bus.dhit) begin
                    pc_en_c   = 1'b1;
                    state_d   = FETCH;
                    imemren_d = 1'b1;
                    dmemren_d = 1'b0;
                    dmemwen_d = 1'b0;
                end
            end
            HALTED: begin
                imemren_d = 1'b0;
                dmemren_d = 1'b0;
                dmemwen_d = 1'b0;
            end
            default: begin
                state_d   = FETCH;
                imemren_d = 1'b1;
                dmemren_d = 1'b0;
                dmemwen_d = 1'b0;
            end
        endcase
    end

    assign mem_wait = (state_q == MEM) && !bus.dhit;

    sat_counter #(
        .W (TO_W)
    ) u_to_cnt (
        .clk     (CLK),
        .rst_n   (nRST),
        .clr_i   (mem_start),
        .en_i    (mem_wait),
        .count_o (to_cnt)
    );

    // Flag rises on the edge the counter would step onto the limit, so a dhit that cycle wins.
    assign to_reach  = TO_EN && mem_wait && (({1'b0, to_cnt} + (TO_W+1)'(1)) == TO_LIMIT);
    assign timeout_d = timeout_q | to_reach;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            imemren_q <= 1'b1;
            dmemren_q <= 1'b0;
            dmemwen_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            imemren_q <= imemren_d;
            dmemren_q <= dmemren_d;
            dmemwen_q <= dmemwen_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.imemREN     = imemren_q;
    assign bus.dmemREN     = dmemren_q;
    assign bus.dmemWEN     = dmemwen_q;
    assign bus.pc_en       = nRST & pc_en_c;
    assign bus.halt        = (state_q == HALTED);
    assign bus.mem_timeout = timeout_q;

`ifdef REQ_PERF_CNT_EN
    logic [WORD_W-1:0] instr_cnt_q;
    logic [WORD_W-1:0] stall_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pc_en_c) begin
                instr_cnt_q <= instr_cnt_q + WORD_W'(1);
            end
            if (state_q == MEM) begin
                stall_cnt_q <= stall_cnt_q + WORD_W'(1);
            end
        end
    end

    assign bus.instr_cnt = instr_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.instr_cnt = '0;
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed plus randomized check of request_unit against a behavioural model
module tb_request_unit;

    localparam int TMO = 4;

    logic CLK;
    logic nRST;
    request_unit_if bus ();

    request_unit #(
        .MEM_TIMEOUT (TMO),
        .TO_W        (8)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed;
    int total;

    // behavioural model: what the sequencer is doing, not how it encodes it
    bit          m_halted;
    bit          m_busy;
    bit          m_is_load;
    int          m_waited;
    bit          m_flag;
    int unsigned m_instr;
    int unsigned m_stall;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
    endtask

    task automatic model_clear();
        m_halted  = 0;
        m_busy    = 0;
        m_is_load = 0;
        m_waited  = 0;
        m_flag    = 0;
        m_instr   = 0;
        m_stall   = 0;
    endtask

    function automatic logic [31:0] perf(input int unsigned v);
`ifdef REQ_PERF_CNT_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // one clock cycle: drive, check at the falling edge, advance the model, step past the rising edge
    task automatic cyc(input bit ih, input bit dh, input bit r, input bit w, input bit ch);
        bit exp_pc;
        bus.ihit    = ih;
        bus.dhit    = dh;
        bus.dcuREN  = r;
        bus.dcuWEN  = w;
        bus.cu_halt = ch;
        @(negedge CLK);
        if (m_halted)    exp_pc = 0;
        else if (m_busy) exp_pc = dh;
        else             exp_pc = ih && !ch && !r && !w;
        chk("imemREN", 32'(bus.imemREN), 32'(!m_halted && !m_busy));
        chk("dmemREN", 32'(bus.dmemREN), 32'(m_busy && m_is_load));
        chk("dmemWEN", 32'(bus.dmemWEN), 32'(m_busy && !m_is_load));
        chk("pc_en", 32'(bus.pc_en), 32'(exp_pc));
        chk("halt", 32'(bus.halt), 32'(m_halted));
        chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_flag));
        chk("instr_cnt", bus.instr_cnt, perf(m_instr));
        chk("stall_cnt", bus.stall_cnt, perf(m_stall));
        if (exp_pc) m_instr++;
        if (!m_halted) begin
            if (m_busy) begin
                m_stall++;
                if (dh) begin
                    m_busy = 0;
                end else begin
                    if (m_waited < 255) m_waited++;
                    if (m_waited == TMO) m_flag = 1;
                end
            end else if (ih) begin
                if (ch) begin
                    m_halted = 1;
                end else if (r || w) begin
                    m_busy    = 1;
                    m_is_load = r;
                    m_waited  = 0;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // asynchronous reset applied mid-cycle; outputs must settle before any clock edge
    task automatic do_reset();
        bus.ihit    = 1'b1;
        bus.dhit    = 1'b1;
        bus.dcuREN  = 1'b0;
        bus.dcuWEN  = 1'b0;
        bus.cu_halt = 1'b0;
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_imemREN", 32'(bus.imemREN), 32'd1);
        chk("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
        chk("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_mem_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("rst_instr_cnt", bus.instr_cnt, 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_clear();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        nRST   = 1'b1;
        model_clear();
        @(posedge CLK);
        #1;
        do_reset();

        // straight-line ALU instructions
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);

        // load served on the third MEM cycle
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // store, with dhit in FETCH ignored beforehand
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);

        // load and store together: the load wins
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // timeout expires, late dhit still completes and flag is sticky
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        do_reset();

        // dhit on the fourth MEM cycle beats the timeout
        cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);

        // reset in the middle of a load aborts it
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(1, 0, 0, 0, 0);

        // halt is terminal
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 1, i[0], ~i[0], 0);
        do_reset();

        // randomized traffic, several independent episodes
        for (int ep = 0; ep < 4; ep++) begin
            for (int i = 0; i < 120; i++) begin
                cyc(($urandom_range(9) < 6), ($urandom_range(9) < 3),
                    ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                    ($urandom_range(99) < 2));
            end
            do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
